// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Supports stall (freeze), flush (squash to bubble) and a saturating kill counter.
module pipe_skid_reg #(
  parameter int unsigned        DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int unsigned        CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  kill_cnt
);

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] KILL_MAX = {2'b00, {CNT_W{1'b1}}};

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    kill_q, kill_d;
  logic                in_hs, out_hs;
  logic [SUM_W-1:0]    kill_sum;

  assign occ      = state_q;
  assign kill_cnt = kill_q;

  // Handshake qualifiers depend only on state, stall and rst.
  always_comb begin
    in_ready  = !rst && !stall && (state_q != FULL);
    out_valid = !rst && !stall && (state_q != EMPTY);
    out_data  = (rst || (state_q == EMPTY)) ? BUBBLE : head_q;
  end

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Entries squashed this cycle: held minus the one leaving, plus the one arriving.
  assign kill_sum = {2'b00, kill_q} + SUM_W'(occ) - SUM_W'(out_hs) + SUM_W'(in_hs);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    kill_d  = kill_q;
    if (flush) begin
      state_d = EMPTY;
      kill_d  = (kill_sum > KILL_MAX) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end else if (!stall) begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            head_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            head_d = in_data;
          end else if (in_hs) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_hs) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Payload storage needs no reset; it is masked by the state.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic against a queue model.
// A second instance with a 2-bit counter and non-zero bubble shares the stimulus.
module tb_pipe_skid_reg;

  localparam logic [63:0] BUB0 = 64'h0;
  localparam logic [63:0] BUB1 = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, stall, flush;
  logic [63:0] in_data;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [1:0]  occ;
  logic [15:0] kill_cnt;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [1:0]  s_occ;
  logic [1:0]  s_kill;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents and the two kill counters.
  logic [63:0] mq[$];
  int          mk16 = 0;
  int          mk2  = 0;

  always #5 clk = ~clk;

  pipe_skid_reg u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .stall(stall),
    .flush(flush), .occ(occ), .kill_cnt(kill_cnt)
  );

  pipe_skid_reg #(.DATA_W(64), .BUBBLE(BUB1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready), .stall(stall),
    .flush(flush), .occ(s_occ), .kill_cnt(s_kill)
  );

  function automatic logic m_in_ready();
    return !rst && !stall && (mq.size() < 2);
  endfunction

  function automatic logic m_out_valid();
    return !rst && !stall && (mq.size() > 0);
  endfunction

  function automatic logic [63:0] m_out_data(input logic [63:0] bub);
    return (rst || mq.size() == 0) ? bub : mq[0];
  endfunction

  // Advance one clock; model follows the handshake rules at the edge.
  task automatic tick();
    logic ih, oh;
    logic [63:0] d;
    int k;
    ih = in_valid && m_in_ready();
    oh = out_ready && m_out_valid();
    d  = in_data;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mk16 = 0;
      mk2  = 0;
    end else if (flush) begin
      k    = mq.size() - int'(oh) + int'(ih);
      mk16 = (mk16 + k > 65535) ? 65535 : mk16 + k;
      mk2  = (mk2 + k > 3) ? 3 : mk2 + k;
      mq.delete();
    end else if (!stall) begin
      if (oh) void'(mq.pop_front());
      if (ih) mq.push_back(d);
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (s_out_data !== BUB1) begin bad++; $display("FAIL rst_bubble: got %h want %h", s_out_data, BUB1); end
    rst = 1'b0;
    #1;
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL rel_occ: got %0d want 0", occ); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== BUB0) begin bad++; $display("FAIL rel_out_data: got %h want 0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    total++; if (kill_cnt !== 16'd0) begin bad++; $display("FAIL rel_kill: got %0d want 0", kill_cnt); end
    tick();
  endtask

  task automatic test_streaming();
    logic [63:0] vals[4];
    vals[0] = 64'h8C08_0004_0040_0004;
    vals[1] = 64'h0109_4020_0040_0008;
    vals[2] = {$urandom, $urandom};
    vals[3] = {$urandom, $urandom};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      tick();
      #1;
      total++; if (out_data !== vals[i]) begin bad++; $display("FAIL stream_data%0d: got %h want %h", i, out_data, vals[i]); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %b want 1", i, out_valid); end
      total++; if (occ !== 2'd1) begin bad++; $display("FAIL stream_occ%0d: got %0d want 1", i, occ); end
    end
    in_valid = 1'b0;
    tick();
    #1;
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL stream_drain: got %0d want 0", occ); end
  endtask

  task automatic test_skid();
    logic [63:0] exp3[3];
    logic [63:0] got[$];
    logic acc;
    exp3[0] = 64'hA0A0_0000_0000_0001;
    exp3[1] = 64'hB0B0_0000_0000_0002;
    exp3[2] = 64'hC0C0_0000_0000_0003;
    in_valid = 1'b1; out_ready = 1'b1; in_data = exp3[0];
    tick();
    out_ready = 1'b0; in_data = exp3[1];
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_accept_b: got %b want 1", in_ready); end
    tick();
    in_data = exp3[2];
    #1;
    total++; if (occ !== 2'd2) begin bad++; $display("FAIL skid_occ2: got %0d want 2", occ); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_backpressure: got %b want 0", in_ready); end
    total++; if (out_data !== exp3[0]) begin bad++; $display("FAIL skid_head: got %h want %h", out_data, exp3[0]); end
    tick();
    #1;
    total++; if (occ !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL skid_c_held: occ %0d rdy %b want 2 0", occ, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (out_data !== m_out_data(BUB0)) begin bad++; $display("FAIL skid_drain%0d: got %h want %h", i, out_data, m_out_data(BUB0)); end
      if (out_valid) got.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    total++; if (got.size() != 3) begin bad++; $display("FAIL skid_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp3[i]) begin
        bad++; $display("FAIL skid_order%0d: got %h want %h", i, (i < got.size()) ? got[i] : 64'hx, exp3[i]);
      end
    end
  endtask

  task automatic test_stall();
    int kb;
    idle_inputs();
    in_valid = 1'b1; in_data = {32'hAAAA_AAAA, 32'hAAAA_AAAA};
    tick();
    kb = mk16;
    stall = 1'b1; out_ready = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_hs%0d: rdy %b vld %b want 0 0", i, in_ready, out_valid); end
      total++; if (occ !== 2'd1 || kill_cnt !== 16'(kb)) begin bad++; $display("FAIL stall_hold%0d: occ %0d kill %0d want 1 %0d", i, occ, kill_cnt, kb); end
      tick();
    end
    stall = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== {32'hAAAA_AAAA, 32'hAAAA_AAAA}) begin bad++; $display("FAIL stall_release: vld %b data %h want 1 aaaa...", out_valid, out_data); end
    tick();
    #1;
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL stall_drain: got %0d want 0", occ); end
  endtask

  task automatic test_flush();
    int kb;
    // Case 1: full, output handshake, input blocked.
    idle_inputs();
    in_valid = 1'b1;
    in_data = {$urandom, $urandom}; tick();
    in_data = {$urandom, $urandom}; tick();
    kb = mk16;
    out_ready = 1'b1; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush1_in_ready: got %b want 0", in_ready); end
    tick();
    idle_inputs();
    #1;
    total++; if (occ !== 2'd0 || out_data !== BUB0) begin bad++; $display("FAIL flush1_clear: occ %0d data %h want 0 0", occ, out_data); end
    total++; if (kill_cnt !== 16'(kb + 1)) begin bad++; $display("FAIL flush1_kill: got %0d want %0d", kill_cnt, kb + 1); end
    // Case 2: one held plus an input handshake.
    in_valid = 1'b1; in_data = {$urandom, $urandom}; tick();
    kb = mk16;
    flush = 1'b1; in_data = {$urandom, $urandom}; tick();
    idle_inputs();
    #1;
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL flush2_occ: got %0d want 0", occ); end
    total++; if (kill_cnt !== 16'(kb + 2)) begin bad++; $display("FAIL flush2_kill: got %0d want %0d", kill_cnt, kb + 2); end
    // Case 3: flush wins over stall.
    in_valid = 1'b1; in_data = {$urandom, $urandom}; tick();
    kb = mk16;
    stall = 1'b1; flush = 1'b1; out_ready = 1'b1; tick();
    idle_inputs();
    #1;
    total++; if (occ !== 2'd0 || s_out_data !== BUB1) begin bad++; $display("FAIL flush3_clear: occ %0d data %h want 0 %h", occ, s_out_data, BUB1); end
    total++; if (kill_cnt !== 16'(kb + 1)) begin bad++; $display("FAIL flush3_kill: got %0d want %0d", kill_cnt, kb + 1); end
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; tick();
      flush = 1'b1; in_data = {$urandom, $urandom}; tick();
      idle_inputs();
      #1;
      total++; if (s_kill !== 2'((2 * (i + 1) > 3) ? 3 : 2 * (i + 1))) begin bad++; $display("FAIL sat_kill%0d: got %0d want %0d", i, s_kill, (2 * (i + 1) > 3) ? 3 : 2 * (i + 1)); end
      total++; if (kill_cnt !== 16'(2 * (i + 1))) begin bad++; $display("FAIL wide_kill%0d: got %0d want %0d", i, kill_cnt, 2 * (i + 1)); end
    end
    tick();
    #1;
    total++; if (s_kill !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d want 3", s_kill); end
    in_valid = 1'b1;
    in_data = {$urandom, $urandom}; tick();
    in_data = {$urandom, $urandom}; tick();
    #1;
    total++; if (occ !== 2'd2) begin bad++; $display("FAIL sat_fill: got %0d want 2", occ); end
    rst = 1'b1; in_valid = 1'b0; tick();
    rst = 1'b0;
    #1;
    total++; if (occ !== 2'd0 || s_occ !== 2'd0) begin bad++; $display("FAIL midrst_occ: got %0d/%0d want 0", occ, s_occ); end
    total++; if (kill_cnt !== 16'd0 || s_kill !== 2'd0) begin bad++; $display("FAIL midrst_kill: got %0d/%0d want 0", kill_cnt, s_kill); end
    total++; if (out_data !== BUB0 || s_out_data !== BUB1) begin bad++; $display("FAIL midrst_bubble: got %h/%h", out_data, s_out_data); end
  endtask

  task automatic test_random();
    int errs;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = {$urandom, $urandom};
      #1;
      errs = 0;
      if (in_ready !== m_in_ready() || s_in_ready !== m_in_ready()) errs++;
      if (out_valid !== m_out_valid() || s_out_valid !== m_out_valid()) errs++;
      if (out_data !== m_out_data(BUB0) || s_out_data !== m_out_data(BUB1)) errs++;
      if (occ !== 2'(mq.size()) || s_occ !== 2'(mq.size())) errs++;
      if (kill_cnt !== 16'(mk16) || s_kill !== 2'(mk2)) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL rand%0d: rdy %b vld %b data %h occ %0d kill %0d/%0d want rdy %b vld %b data %h occ %0d kill %0d/%0d",
                 i, in_ready, out_valid, out_data, occ, kill_cnt, s_kill,
                 m_in_ready(), m_out_valid(), m_out_data(BUB0), mq.size(), mk16, mk2);
      end
      tick();
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_stall();
    test_flush();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
